reaction_ctrl_fsm: RTL
======================

# reaction_ctrl_fsm

Sequencing controller for the reaction-timer game on the Nexys A7 board. It takes the debounced clear/start/stop button levels and runs one trial. Each trial is a pseudo-random wait, then a lit LED while a millisecond count runs. The trial ends on a valid stop, an early "cheat" stop, or a timeout. The block drives the reaction LED and supplies a binary result and a display mode to the existing seven-segment display path.

## Interface

Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz clock).
- DELAY_MIN_MS, 2000: minimum random wait in ms.
- DELAY_BITS, 12: number of LFSR bits added to the wait (wait range DELAY_MIN_MS .. DELAY_MIN_MS+2^DELAY_BITS-1).
- MAX_MS, 1000: timeout value. Must be ≤ 9998.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- btn_clr  in  1  debounced clear level.
- btn_start  in  1  debounced start level.
- btn_stop  in  1  debounced stop level.
- led  out  1  reaction LED; high only in TIMING.
- result  out  14  binary ms value for the display.
- disp_mode  out  2  00 idle/blank, 01 show result, 10 cheat.
- state  out  3  current state, for debug.

## Operation

- Button edge detect: each button has a sampled copy btn_q, which reset sets to 1. An edge is btn=1 and btn_q=0, evaluated combinationally and acted on at the same clk edge. Because btn_q resets to 1, a button held through reset produces no edge.
- Edge priority: clr > stop > start.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It resets to 16'hACE1 and advances every cycle (free-running).
- ms tick prescaler:
  - Counts 0..TICK_DIV-1 and pulses tick when it equals TICK_DIV-1.
  - Cleared to 0 on entry to WAIT and to TIMING, so the first ms is always full length.
- State encodings: IDLE=0, WAIT=1, TIMING=2, DONE=3, CHEAT=4, TIMEOUT=5.
- IDLE: led=0, result=0, disp_mode=00.
  - start edge → WAIT; delay counter (16 bits) loads DELAY_MIN_MS + lfsr[DELAY_BITS-1:0].
- WAIT: disp_mode=00. On each tick the delay counter decrements.
  - stop edge → CHEAT.
  - A tick with delay counter = 1 → TIMING, with count=0 and led=1 from that edge.
- TIMING: led=1, disp_mode=01, result=live count. On each tick count increments.
  - stop edge → DONE, count frozen. A stop that coincides with a tick wins: no increment.
  - The increment that makes count reach MAX_MS → TIMEOUT.
- DONE: led=0, disp_mode=01, result holds the frozen count.
- TIMEOUT: led=0, disp_mode=01, result=MAX_MS.
- CHEAT: led=0, disp_mode=10, result=9999.
- Holding in end states: DONE, CHEAT and TIMEOUT ignore start and stop edges and hold until a clr edge.
- clr edge in any state → IDLE, result=0. This includes a simultaneous start edge: the block stays in IDLE.
- start edges outside IDLE are ignored. stop edges in IDLE are ignored.

## Timing

- Reset values (asynchronous, immediate): state=IDLE, led=0, result=0, disp_mode=00, prescaler=0, LFSR=16'hACE1, all btn_q=1.
- All outputs are registered.
- Latency: outputs change at the first clk edge where the qualifying edge or tick condition holds.
- Button-to-output latency is 1 cycle from the cycle in which the button is sampled high.
- WAIT lasts exactly D×TICK_DIV cycles, where D is the loaded delay.
- result in TIMING equals the number of complete ms elapsed since led rose.
- Reset mid-operation aborts immediately; no state is retained.

## Test plan

Sim parameters: TICK_DIV=4, DELAY_MIN_MS=2, DELAY_BITS=2, MAX_MS=10. The bench carries a reference LFSR model.

- Normal trial:
  - Stimulus: reset, then start pulse; D=2+lfsr[1:0] at the start edge.
  - Required: led rises exactly 4D cycles after the start edge.
  - Stimulus: stop 7 ticks later.
  - Required: result=7, disp_mode=01, led=0. Values hold through 50 cycles of start/stop pulses; clr then gives result=0, IDLE.
- Cheat: stop during WAIT → state=CHEAT, result=9999, disp_mode=10, led never 1. A following start is ignored.
- Timeout: start, no stop → result counts 0..10, then state=TIMEOUT, led=0, result=10.
- Simultaneous events:
  - Stop coinciding with the tick that would reach 6 → result=5.
  - clr and start in the same cycle in DONE → IDLE, no WAIT entered.
- Reset:
  - Assert rst mid-TIMING → led=0, result=0, state=0 before the next clk edge.
  - Release rst with btn_start held high → no WAIT until the button is released and pressed again.

Source files
------------

// File: rtl/reaction_ctrl_fsm_if.sv
// rtl/reaction_ctrl_fsm_if.sv - button inputs and display outputs of the reaction-timer controller
interface reaction_ctrl_fsm_if;
  logic        btn_clr;
  logic        btn_start;
  logic        btn_stop;
  logic        led;
  logic [13:0] result;
  logic [1:0]  disp_mode;
  logic [2:0]  state;

  modport master (
    output btn_clr, btn_start, btn_stop,
    input  led, result, disp_mode, state
  );

  modport slave (
    input  btn_clr, btn_start, btn_stop,
    output led, result, disp_mode, state
  );
endinterface

// File: rtl/reaction_ctrl_fsm.sv
// rtl/reaction_ctrl_fsm.sv - reaction-timer trial sequencer: random wait, timed LED, stop/cheat/timeout
module reaction_ctrl_fsm #(
  parameter int TICK_DIV     = 100000,
  parameter int DELAY_MIN_MS = 2000,
  parameter int DELAY_BITS   = 12,
  parameter int MAX_MS       = 1000
) (
  input  logic                clk,
  input  logic                rst,
  reaction_ctrl_fsm_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_TIMING  = 3'd2,
    S_DONE    = 3'd3,
    S_CHEAT   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t        state_q, state_n;
  logic          clr_q, start_q, stop_q;
  logic          clr_e, start_e, stop_e;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic          tick;
  logic          presc_clr;
  logic [15:0]   delay_q, delay_n;
  logic [13:0]   count_q, count_n;
  logic          led_q, led_n;
  logic [13:0]   result_q, result_n;
  logic [1:0]    mode_q, mode_n;

  // Button history; reset to 1 so a button held through reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q   <= 1'b1;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      clr_q   <= bus.btn_clr;
      start_q <= bus.btn_start;
      stop_q  <= bus.btn_stop;
    end
  end

  assign clr_e   = bus.btn_clr   & ~clr_q;
  assign start_e = bus.btn_start & ~start_q;
  assign stop_e  = bus.btn_stop  & ~stop_q;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying the random wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Millisecond prescaler; restarted on WAIT/TIMING entry so the first ms is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    presc <= '0;
    else if (presc_clr || tick) presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  // Next-state and next-output decode; clr overrides everything.
  always_comb begin
    state_n   = state_q;
    delay_n   = delay_q;
    count_n   = count_q;
    presc_clr = 1'b0;
    led_n     = 1'b0;
    result_n  = result_q;
    mode_n    = mode_q;
    if (clr_e) begin
      state_n  = S_IDLE;
      result_n = 14'd0;
      mode_n   = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          result_n = 14'd0;
          mode_n   = 2'b00;
          if (start_e) begin
            state_n   = S_WAIT;
            delay_n   = 16'(DELAY_MIN_MS) + 16'(lfsr[DELAY_BITS-1:0]);
            presc_clr = 1'b1;
          end
        end
        S_WAIT: begin
          mode_n = 2'b00;
          if (stop_e) begin
            state_n  = S_CHEAT;
            result_n = 14'd9999;
            mode_n   = 2'b10;
          end else if (tick) begin
            if (delay_q <= 16'd1) begin
              state_n   = S_TIMING;
              count_n   = 14'd0;
              result_n  = 14'd0;
              mode_n    = 2'b01;
              led_n     = 1'b1;
              presc_clr = 1'b1;
            end else begin
              delay_n = delay_q - 16'd1;
            end
          end
        end
        S_TIMING: begin
          led_n  = 1'b1;
          mode_n = 2'b01;
          if (stop_e) begin
            state_n  = S_DONE;
            led_n    = 1'b0;
            result_n = count_q;
          end else if (tick) begin
            if (count_q + 14'd1 == 14'(MAX_MS)) begin
              state_n  = S_TIMEOUT;
              led_n    = 1'b0;
              count_n  = 14'(MAX_MS);
              result_n = 14'(MAX_MS);
            end else begin
              count_n  = count_q + 14'd1;
              result_n = count_q + 14'd1;
            end
          end
        end
        S_DONE, S_CHEAT, S_TIMEOUT: begin
          led_n = 1'b0;
        end
        default: begin
          state_n  = S_IDLE;
          result_n = 14'd0;
          mode_n   = 2'b00;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      delay_q  <= 16'd0;
      count_q  <= 14'd0;
      led_q    <= 1'b0;
      result_q <= 14'd0;
      mode_q   <= 2'b00;
    end else begin
      state_q  <= state_n;
      delay_q  <= delay_n;
      count_q  <= count_n;
      led_q    <= led_n;
      result_q <= result_n;
      mode_q   <= mode_n;
    end
  end

  assign bus.led       = led_q;
  assign bus.result    = result_q;
  assign bus.disp_mode = mode_q;
  assign bus.state     = state_q;

endmodule
